booth_pp_accum: RTL

Serial partial-product accumulator for the radix-4 Booth multiplier. It consumes the 36-bit sign-encoded partial products from the partial-product generators one row per beat, in row order (first, mids, last), over a valid/ready handshake. It aligns and sums the rows into the 64-bit product and presents the product on a valid/ready result port. It sits directly downstream of the partial-product stage and replaces the combinational compression tree in area-constrained builds.

---
 rtl/booth_pp_accum.sv | 105 ++++++++++
 1 files changed

// File: rtl/booth_pp_accum.sv
// Serial accumulator for radix-4 Booth partial products: one 36-bit row per beat, summed into a 64-bit product.
// Define BOOTH_PP_ACCUM_OVLP_EN to accept the next product's row 0 in the same cycle the result is taken.
module booth_pp_accum #(
    parameter int NUM_PP = 17,
    parameter int PP_W   = 36,
    parameter int RES_W  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             abort,
    input  logic             pp_valid,
    output logic             pp_ready,
    input  logic [PP_W-1:0]  pp_data,
    output logic [4:0]       pp_idx,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [RES_W-1:0] res_data
);

    typedef enum logic {ACC, DONE} state_e;

    localparam logic [4:0] LAST_IDX = 5'(NUM_PP - 1);

    state_e           state_q, state_d;
    logic [RES_W-1:0] acc_q, acc_d;
    logic [4:0]       idx_q, idx_d;

    logic             accept;
    logic             take;
    logic [5:0]       shamt;
    logic [RES_W-1:0] pp_ext;
    logic [RES_W-1:0] addend;

`ifdef BOOTH_PP_ACCUM_OVLP_EN
    assign pp_ready = (state_q == ACC) || res_ready;
`else
    assign pp_ready = (state_q == ACC);
`endif

    assign res_valid = (state_q == DONE);
    assign res_data  = acc_q;
    assign pp_idx    = idx_q;

    assign accept = pp_valid && pp_ready;
    assign take   = res_valid && res_ready;

    // Row k>=1 lands at 2^(2k-2): its 2 LSBs hold the previous row's +1 negation correction.
    // No sign extension: the encoding constants only cancel modulo 2^RES_W.
    assign shamt  = (idx_q == 5'd0) ? 6'd0 : ({idx_q, 1'b0} - 6'd2);
    assign pp_ext = RES_W'(pp_data);
    assign addend = pp_ext << shamt;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        if (abort) begin
            state_d = ACC;
            idx_d   = 5'd0;
        end else begin
            case (state_q)
                ACC: begin
                    if (accept) begin
                        acc_d = (idx_q == 5'd0) ? pp_ext : (acc_q + addend);
                        if (idx_q == LAST_IDX) begin
                            state_d = DONE;
                            idx_d   = 5'd0;
                        end else begin
                            idx_d = idx_q + 5'd1;
                        end
                    end
                end
                DONE: begin
                    if (take) begin
                        state_d = ACC;
`ifdef BOOTH_PP_ACCUM_OVLP_EN
                        // Overlapped beat becomes row 0 of the next product.
                        if (accept) begin
                            acc_d = pp_ext;
                            idx_d = 5'd1;
                        end
`endif
                    end
                end
                default: begin
                    state_d = ACC;
                    idx_d   = 5'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACC;
            acc_q   <= '0;
            idx_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
        end
    end

endmodule
